shift_link_tx: RTL

- Transmitter end of the serial-to-parallel output path built from daisy-chained 74595 shift registers.
- Accepts a parallel word over a valid/ready handshake and serializes it onto SER/SRCLK.
- Ends each word with an RCLK pulse so the 74595 chain's outputs update atomically.
- Sits between the CPU I/O write port and the ic74595 chain models in the board-level simulation.

---
 rtl/shift_link_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_link_tx.sv
// shift_link_tx: serializes a parallel word onto a 74595 chain (SER/SRCLK),
// then pulses RCLK so the chain outputs update atomically.
module shift_link_tx #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV       = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    // Reject illegal parameterisations at elaboration time.
    if (DIV < 1) begin : g_bad_div
        $error("shift_link_tx: DIV must be at least 1");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("shift_link_tx: WIDTH must be in 1..64");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic [WIDTH-1:0] sr_adv;
    logic             head_adv;
    logic             head_load;
    logic             div_last;

    // Shift register advanced by one bit, its new head, and phase-end detect.
    always_comb begin
        sr_adv    = MSB_FIRST ? (sr << 1) : (sr >> 1);
        head_adv  = MSB_FIRST ? sr_adv[WIDTH-1] : sr_adv[0];
        head_load = MSB_FIRST ? data[WIDTH-1] : data[0];
        div_last  = (div_cnt == DIV_W'(DIV - 1));
    end

    // Transmit FSM with registered pin outputs; each phase lasts DIV cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            ser     <= 1'b0;
            srclk   <= 1'b0;
            rclk    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        sr      <= data;
                        bit_cnt <= CNT_W'(WIDTH);
                        div_cnt <= '0;
                        ser     <= head_load;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b0;
                        sr      <= sr_adv;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == CNT_W'(1)) begin
                            rclk  <= 1'b1;
                            ser   <= 1'b0;
                            state <= LATCH;
                        end else begin
                            ser   <= head_adv;
                            state <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        rclk    <= 1'b0;
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
